// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 timing constants and sizing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int c_def_h_active = 640;
    localparam int c_def_h_fp     = 16;
    localparam int c_def_h_sync   = 96;
    localparam int c_def_h_bp     = 48;
    localparam int c_def_v_active = 480;
    localparam int c_def_v_fp     = 10;
    localparam int c_def_v_sync   = 2;
    localparam int c_def_v_bp     = 33;

    function automatic int vga_total(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Smallest width able to hold max(h_total, v_total) - 1, at least 1 bit.
    function automatic int vga_cw_required(input int h_total, input int v_total);
        int max_last;
        int w;
        max_last = ((h_total > v_total) ? h_total : v_total) - 1;
        w = 1;
        while ((max_last >> w) != 0) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// Module      : vga_axis_counter
// Description : Modulo-TOTAL raster axis counter with count-enable and wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int CW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] c_last = CW'(TOTAL - 1);

    logic [CW-1:0] r_count;

    // Combinational so the next axis can advance on the same edge.
    assign wrap  = ce && (r_count == c_last);
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (wrap) begin
            r_count <= '0;
        end else if (ce) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator on a pixel clock-enable.
//               Optional macro VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = c_def_h_active,
    parameter int H_FP      = c_def_h_fp,
    parameter int H_SYNC    = c_def_h_sync,
    parameter int H_BP      = c_def_h_bp,
    parameter int V_ACTIVE  = c_def_v_active,
    parameter int V_FP      = c_def_v_fp,
    parameter int V_SYNC    = c_def_v_sync,
    parameter int V_BP      = c_def_v_bp,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0]    frame_cnt
`endif
);

    localparam int c_h_total = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] c_h_act      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_v_act      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_hs_start   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_hs_end     = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] c_vs_start   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_vs_end     = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
            CW < vga_cw_required(c_h_total, c_v_total)) begin : g_param_check
            $error("vga_timing_gen: zero-width timing field or CW too small");
        end
    endgenerate

    logic [CW-1:0] w_h;
    logic [CW-1:0] w_v;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_de;

    vga_axis_counter #(.TOTAL(c_h_total), .CW(CW)) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .ce    (pix_ce),
        .count (w_h),
        .wrap  (w_h_wrap)
    );

    vga_axis_counter #(.TOTAL(c_v_total), .CW(CW)) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .ce    (w_h_wrap),
        .count (w_v),
        .wrap  (w_v_wrap)
    );

    assign w_hs_act = (w_h >= c_hs_start) && (w_h <= c_hs_end);
    assign w_vs_act = (w_v >= c_vs_start) && (w_v <= c_vs_end);
    assign w_de     = (w_h < c_h_act) && (w_v < c_v_act);

    // Flags marking that the counters now sit at a freshly entered origin.
    logic r_first;
    logic r_line_wrapped;
    logic r_frame_wrapped;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first         <= 1'b1;
            r_line_wrapped  <= 1'b0;
            r_frame_wrapped <= 1'b0;
            hsync           <= ~HSYNC_POL;
            vsync           <= ~VSYNC_POL;
            display_on      <= 1'b0;
            hpos            <= '0;
            vpos            <= '0;
            line_start      <= 1'b0;
            frame_start     <= 1'b0;
        end else begin
            r_first         <= 1'b0;
            r_line_wrapped  <= w_h_wrap;
            r_frame_wrapped <= w_v_wrap;
            hsync           <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync           <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
            display_on      <= w_de;
            hpos            <= w_h;
            vpos            <= w_v;
            line_start      <= r_first | r_line_wrapped;
            frame_start     <= r_first | r_frame_wrapped;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Counts only real frame wraps, so the post-reset strobe is excluded.
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= 8'd0;
        end else if (r_frame_wrapped) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed self-checking bench for vga_timing_gen (three configs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b1;
    logic pix_ce = 1'b0;

    int checks = 0;
    int passed = 0;

    // Default 640x480 instance
    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_hpos, d_vpos;
    // Small override instance (12 x 7, hsync active high)
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [3:0] s_hpos, s_vpos;
    // Short lines with default vertical timing
    logic       v_hs, v_vs, v_de, v_ls, v_fs;
    logic [9:0] v_hpos, v_vpos;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] d_fc, s_fc, v_fc;
`endif

    vga_timing_gen u_dut_d (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .hsync(d_hs), .vsync(d_vs), .display_on(d_de),
        .hpos(d_hpos), .vpos(d_vpos),
        .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(d_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(4)
    ) u_dut_s (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .hsync(s_hs), .vsync(s_vs), .display_on(s_de),
        .hpos(s_hpos), .vpos(s_vpos),
        .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(s_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1)
    ) u_dut_v (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .hsync(v_hs), .vsync(v_vs), .display_on(v_de),
        .hpos(v_hpos), .vpos(v_vpos),
        .line_start(v_ls), .frame_start(v_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(v_fc)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [24:0] exp_d;
        rst = 1'b1;
        pix_ce = 1'b0;
        tick();
        exp_d = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
        checks++;
        if ({d_hs, d_vs, d_de, d_ls, d_fs, d_hpos, d_vpos} !== exp_d)
            $display("FAIL reset_default got=%h exp=%h", {d_hs, d_vs, d_de, d_ls, d_fs, d_hpos, d_vpos}, exp_d);
        else passed++;
        checks++;
        if ({s_hs, s_vs, s_de, s_ls, s_fs, s_hpos, s_vpos} !== {5'b01000, 4'd0, 4'd0})
            $display("FAIL reset_small got=%h exp=%h", {s_hs, s_vs, s_de, s_ls, s_fs, s_hpos, s_vpos}, {5'b01000, 8'd0});
        else passed++;
        checks++;
        if ({v_hs, v_vs, v_de, v_ls, v_fs, v_hpos, v_vpos} !== exp_d)
            $display("FAIL reset_vert got=%h exp=%h", {v_hs, v_vs, v_de, v_ls, v_fs, v_hpos, v_vpos}, exp_d);
        else passed++;
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if ({d_fc, s_fc, v_fc} !== 24'd0)
            $display("FAIL reset_frame_cnt got=%h exp=0", {d_fc, s_fc, v_fc});
        else passed++;
`endif
        // Release with pix_ce low: origin strobes still appear once
        rst = 1'b0;
        tick();
        exp_d = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
        checks++;
        if ({d_hs, d_vs, d_de, d_ls, d_fs, d_hpos, d_vpos} !== exp_d)
            $display("FAIL release_first got=%h exp=%h", {d_hs, d_vs, d_de, d_ls, d_fs, d_hpos, d_vpos}, exp_d);
        else passed++;
        tick();
        exp_d = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};
        checks++;
        if ({d_hs, d_vs, d_de, d_ls, d_fs, d_hpos, d_vpos} !== exp_d)
            $display("FAIL release_hold got=%h exp=%h", {d_hs, d_vs, d_de, d_ls, d_fs, d_hpos, d_vpos}, exp_d);
        else passed++;
    endtask

    task automatic test_default_line();
        int h, v, low_cnt;
        logic [24:0] exp_v;
        low_cnt = 0;
        apply_reset();
        pix_ce = 1'b1;
        for (int k = 1; k <= 1700; k++) begin
            tick();
            h = (k - 1) % 800;
            v = (k - 1) / 800;
            exp_v = {!(h >= 656 && h <= 751), 1'b1, (h < 640), (h == 0), (k == 1), 10'(h), 10'(v)};
            if (k <= 800 && d_hs == 1'b0) low_cnt++;
            checks++;
            if ({d_hs, d_vs, d_de, d_ls, d_fs, d_hpos, d_vpos} !== exp_v)
                $display("FAIL default_line k=%0d got=%h exp=%h", k, {d_hs, d_vs, d_de, d_ls, d_fs, d_hpos, d_vpos}, exp_v);
            else passed++;
        end
        checks++;
        if (low_cnt !== 96) $display("FAIL hsync_width got=%0d exp=96", low_cnt);
        else passed++;
    endtask

    task automatic test_pix_ce_toggle();
        int h, v;
        logic [24:0] exp_v;
        apply_reset();
        for (int k = 1; k <= 1700; k++) begin
            pix_ce = (k % 2) == 1;
            tick();
            h = (k / 2) % 800;
            v = (k >= 1600) ? 1 : 0;
            exp_v = {!(h >= 656 && h <= 751), 1'b1, (h < 640), (k == 1 || k == 1600), (k == 1), 10'(h), 10'(v)};
            checks++;
            if ({d_hs, d_vs, d_de, d_ls, d_fs, d_hpos, d_vpos} !== exp_v)
                $display("FAIL pix_ce_toggle k=%0d got=%h exp=%h", k, {d_hs, d_vs, d_de, d_ls, d_fs, d_hpos, d_vpos}, exp_v);
            else passed++;
        end
    endtask

    task automatic test_small_override();
        int h, v;
        logic [12:0] exp_v;
        apply_reset();
        pix_ce = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            h = (k - 1) % 12;
            v = ((k - 1) / 12) % 7;
            exp_v = {(h == 9 || h == 10), (v != 5), (h < 8 && v < 4), (h == 0), (h == 0 && v == 0), 4'(h), 4'(v)};
            checks++;
            if ({s_hs, s_vs, s_de, s_ls, s_fs, s_hpos, s_vpos} !== exp_v)
                $display("FAIL small_override k=%0d got=%h exp=%h", k, {s_hs, s_vs, s_de, s_ls, s_fs, s_hpos, s_vpos}, exp_v);
            else passed++;
        end
    endtask

    task automatic test_default_vertical();
        int h, v;
        logic [24:0] exp_v;
        apply_reset();
        pix_ce = 1'b1;
        for (int k = 1; k <= 6400; k++) begin
            tick();
            h = (k - 1) % 12;
            v = ((k - 1) / 12) % 525;
            exp_v = {!(h == 9 || h == 10), !(v == 490 || v == 491), (h < 8 && v < 480),
                     (h == 0), (h == 0 && v == 0), 10'(h), 10'(v)};
            checks++;
            if ({v_hs, v_vs, v_de, v_ls, v_fs, v_hpos, v_vpos} !== exp_v)
                $display("FAIL default_vertical k=%0d got=%h exp=%h", k, {v_hs, v_vs, v_de, v_ls, v_fs, v_hpos, v_vpos}, exp_v);
            else passed++;
        end
    endtask

    task automatic test_mid_frame_reset();
        logic found;
        found = 1'b0;
        apply_reset();
        pix_ce = 1'b1;
        for (int k = 0; k < 3000 && !found; k++) begin
            tick();
            if (v_hpos == 10'd5 && v_vpos == 10'd200) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) $display("FAIL mid_reset_reach got=%b exp=1", found);
        else passed++;
        rst = 1'b1;
        tick();
        checks++;
        if ({v_hs, v_vs, v_de, v_ls, v_fs, v_hpos, v_vpos} !== {5'b11000, 10'd0, 10'd0})
            $display("FAIL mid_reset_values got=%h exp=%h", {v_hs, v_vs, v_de, v_ls, v_fs, v_hpos, v_vpos}, {5'b11000, 20'd0});
        else passed++;
        rst = 1'b0;
        tick();
        checks++;
        if ({v_hs, v_vs, v_de, v_ls, v_fs, v_hpos, v_vpos} !== {5'b11111, 10'd0, 10'd0})
            $display("FAIL mid_reset_restart got=%h exp=%h", {v_hs, v_vs, v_de, v_ls, v_fs, v_hpos, v_vpos}, {5'b11111, 20'd0});
        else passed++;
        tick();
        checks++;
        if ({v_hs, v_vs, v_de, v_ls, v_fs, v_hpos, v_vpos} !== {5'b11100, 10'd1, 10'd0})
            $display("FAIL mid_reset_next got=%h exp=%h", {v_hs, v_vs, v_de, v_ls, v_fs, v_hpos, v_vpos}, {5'b11100, 10'd1, 10'd0});
        else passed++;
    endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
    task automatic test_frame_cnt();
        apply_reset();
        pix_ce = 1'b1;
        for (int k = 1; k <= 1 + 84 * 256; k++) begin
            tick();
            if (k == 1 || k == 86) begin
                checks++;
                if (s_fc !== ((k == 1) ? 8'd0 : 8'd1))
                    $display("FAIL frame_cnt_start k=%0d got=%0d exp=%0d", k, s_fc, (k == 1) ? 0 : 1);
                else passed++;
            end
            if (k == 84 * 255) begin
                checks++;
                if (s_fc !== 8'd254) $display("FAIL frame_cnt_254 got=%0d exp=254", s_fc);
                else passed++;
            end
            if (k == 1 + 84 * 255) begin
                checks++;
                if (s_fc !== 8'd255) $display("FAIL frame_cnt_255 got=%0d exp=255", s_fc);
                else passed++;
            end
            if (k == 1 + 84 * 256) begin
                checks++;
                if (s_fc !== 8'd0) $display("FAIL frame_cnt_wrap got=%0d exp=0", s_fc);
                else passed++;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default_line();
        test_pix_ce_toggle();
        test_small_override();
        test_default_vertical();
        test_mid_frame_reset();
`ifdef VGA_TIMING_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
